// File: rtl/scsi_pkg.sv
// Shared types and constants for the SCSI DMA bus-master sequencer.
package scsi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        OWN  = 3'd2,
        FCS  = 3'd3,
        ACK  = 3'd4,
        ERR  = 3'd5,
        END  = 3'd6
    } master_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for active-low asynchronous inputs; resets to the inactive level (1).
module sync2 (
    input  logic CLK,
    input  logic RESET_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/scsi_master_cycle.sv
// Zorro III bus-master sequencer for SCSI DMA: arbitration, FCS cycles, STA/STEA to the chip.
// Define MASTER_TIMEOUT_EN to add the DTACK timeout counter and the ERR (STEA_n) path.
module scsi_master_cycle #(
    parameter int unsigned TIMEOUT_CYCLES = scsi_pkg::TIMEOUT_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic SBR_n,
    input  logic SMAS_n,
    input  logic SREAD,
    input  logic BG_n,
    input  logic DTACK_n,
    output logic zorro_br,
    output logic bus_owned,
    output logic master_fcs,
    output logic master_read,
    output logic master_doe,
    output logic SBG_n,
    output logic STA_n,
    output logic STEA_n
);

    import scsi_pkg::*;

    logic bg_n_s, dtack_n_s;
    logic bg, dtack;

    sync2 u_sync_bg (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .d       (BG_n),
        .q       (bg_n_s)
    );

    sync2 u_sync_dtack (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .d       (DTACK_n),
        .q       (dtack_n_s)
    );

    assign bg    = ~bg_n_s;
    assign dtack = ~dtack_n_s;

    master_state_t state_q, state_d;
    logic read_d;
    logic br_d, owned_d, fcs_d, doe_d, sta_n_d;

`ifdef MASTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic       stea_n_d;
`endif

    always_comb begin
        state_d = state_q;
        read_d  = master_read;
`ifdef MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (!SBR_n) state_d = REQ;
            REQ: begin
                if (bg)         state_d = OWN;
                else if (SBR_n) state_d = IDLE;
            end
            OWN: begin
                if (!SMAS_n) begin
                    state_d = FCS;
                    read_d  = SREAD;
`ifdef MASTER_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else if (SBR_n) begin
                    state_d = IDLE;
                end
            end
            // A chip abort (SMAS_n released) takes priority over a late DTACK.
            FCS: begin
                if (SMAS_n)     state_d = END;
                else if (dtack) state_d = ACK;
`ifdef MASTER_TIMEOUT_EN
                else if (cnt_q >= TimeoutMax) state_d = ERR;
                else if (cnt_q != 8'hFF)      cnt_d = cnt_q + 8'd1;
`endif
            end
            ACK: state_d = END;
`ifdef MASTER_TIMEOUT_EN
            ERR: state_d = END;
`endif
            END: if (SMAS_n && !dtack) state_d = OWN;
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so every output is a flop.
        br_d    = (state_d == REQ);
        owned_d = (state_d inside {OWN, FCS, ACK, ERR, END});
        fcs_d   = (state_d inside {FCS, ACK, ERR});
        doe_d   = fcs_d && !read_d;
        sta_n_d = (state_d != ACK);
`ifdef MASTER_TIMEOUT_EN
        stea_n_d = (state_d != ERR);
`endif
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            zorro_br    <= 1'b0;
            bus_owned   <= 1'b0;
            master_fcs  <= 1'b0;
            master_read <= 1'b0;
            master_doe  <= 1'b0;
            SBG_n       <= 1'b1;
            STA_n       <= 1'b1;
        end else begin
            state_q     <= state_d;
            zorro_br    <= br_d;
            bus_owned   <= owned_d;
            master_fcs  <= fcs_d;
            master_read <= read_d;
            master_doe  <= doe_d;
            SBG_n       <= ~owned_d;
            STA_n       <= sta_n_d;
        end
    end

`ifdef MASTER_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q  <= 8'd0;
            STEA_n <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            STEA_n <= stea_n_d;
        end
    end
`else
    assign STEA_n = 1'b1;
`endif

endmodule
